// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: syncs and debounces two buttons into start/stop/lap/clear commands driving run/clr/lap_hold.
// Optional lap counter output lap_cnt is enabled by defining STOPWATCH_LAP_CNT_EN.
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lc,
    output logic       run,
    output logic       clr,
    output logic       lap_hold,
    output logic [1:0] state
`ifdef STOPWATCH_LAP_CNT_EN
    ,
    output logic [3:0] lap_cnt
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2, LAP = 2'd3} state_t;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    logic [1:0] btn, s1, s2, db, db_d, ev;
    logic [DB_W-1:0] cnt [2];
    state_t cur, nxt;
    logic nxt_clr, ss, lc;
    assign btn = {btn_lc, btn_ss};
    assign ss = ev[0];
    assign lc = ev[1];
    assign state = cur;
    // bit 0 = start/stop, bit 1 = lap/clear; press pulse is registered, adding one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            db <= '0;
            db_d <= '0;
            ev <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            db_d <= db;
            ev <= db & ~db_d;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) cnt[i] <= '0;
                else if (cnt[i] == DB_LAST) begin
                    cnt[i] <= '0;
                    db[i] <= ~db[i];
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    // start/stop has priority; a simultaneous lap/clear is dropped
    always_comb begin
        nxt = cur;
        nxt_clr = 1'b0;
        if (ss) nxt = (cur == RUN || cur == LAP) ? STOP : RUN;
        else if (lc) begin
            nxt = cur == RUN ? LAP : cur == LAP ? RUN : IDLE;
            nxt_clr = cur == IDLE || cur == STOP;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur <= IDLE;
            run <= 1'b0;
            clr <= 1'b0;
            lap_hold <= 1'b0;
        end else begin
            cur <= nxt;
            run <= nxt == RUN || nxt == LAP;
            clr <= nxt_clr;
            lap_hold <= nxt == LAP;
        end
    end
`ifdef STOPWATCH_LAP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lap_cnt <= '0;
        else if (nxt_clr) lap_cnt <= '0;
        else if (cur == RUN && nxt == LAP && lap_cnt != 4'd15) lap_cnt <= lap_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench; stimulus queues expected output changes with their cycle, a monitor checks them.
module tb_stopwatch_ctrl;
    logic clk = 1'b0, rst = 1'b1, btn_ss = 1'b0, btn_lc = 1'b0;
    logic run, clr, lap_hold;
    logic [1:0] state;
    logic [3:0] lap;
    typedef struct packed {
        int         cyc;
        logic [1:0] st;
        logic       run;
        logic       lh;
        logic       clr;
        logic [3:0] lap;
    } rec_t;
    rec_t q[$];
    rec_t e;
    int checks = 0, errors = 0, cyc = 0;
    bit mon_en = 1'b0;
    logic [8:0] snap, prev;
`ifdef STOPWATCH_LAP_CNT_EN
    stopwatch_ctrl dut (.clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lc(btn_lc), .run(run), .clr(clr),
                        .lap_hold(lap_hold), .state(state), .lap_cnt(lap));
`else
    stopwatch_ctrl dut (.clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lc(btn_lc), .run(run), .clr(clr),
                        .lap_hold(lap_hold), .state(state));
    assign lap = 4'd0;
`endif
    assign snap = {state, run, lap_hold, clr, lap};
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (mon_en && snap !== prev) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%h required=no change from %h", cyc, snap, prev);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || snap !== {e.st, e.run, e.lh, e.clr, e.lap}) begin
                    errors++;
                    $display("FAIL output_change got cyc=%0d st/run/lh/clr/lap=%h required cyc=%0d %h",
                             cyc, snap, e.cyc, {e.st, e.run, e.lh, e.clr, e.lap});
                end
            end
            prev = snap;
        end
    end
    function automatic logic [3:0] lv(input int x);
`ifdef STOPWATCH_LAP_CNT_EN
        return 4'(x);
`else
        return 4'd0 & 4'(x);
`endif
    endfunction
    function automatic rec_t mk(input int c, input logic [1:0] st, input logic r, lh, cp, input logic [3:0] lp);
        rec_t t;
        t.cyc = c;
        t.st = st;
        t.run = r;
        t.lh = lh;
        t.clr = cp;
        t.lap = lp;
        return t;
    endfunction
    // raw press seen at edge k+1 changes outputs at edge k+8 (sync 2 + debounce 4 + pulse 1 + state 1)
    task automatic step(input bit ss, lc, input int hold, input bit chg, input logic [1:0] st,
                        input logic r, lh, cp, input logic [3:0] lp);
        int k;
        @(negedge clk);
        k = cyc;
        btn_ss = ss;
        btn_lc = lc;
        if (chg) begin
            q.push_back(mk(k + 8, st, r, lh, cp, lp));
            if (cp) q.push_back(mk(k + 9, st, r, lh, 1'b0, lp));
        end
        repeat (hold) @(negedge clk);
        btn_ss = 1'b0;
        btn_lc = 1'b0;
        repeat (14) @(negedge clk);
    endtask
    initial begin
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            btn_ss = ~btn_ss;
            btn_lc = (i % 2) == 0;
            checks++;
            if (snap !== 9'd0) begin
                errors++;
                $display("FAIL reset_state got=%h required=000", snap);
            end
        end
        @(negedge clk);
        btn_ss = 1'b0;
        btn_lc = 1'b0;
        rst = 1'b1;
        prev = 9'd0;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        step(1, 0, 2, 0, 2'd0, 0, 0, 0, lv(0));
        step(1, 0, 20, 1, 2'd1, 1, 0, 0, lv(0));
        step(0, 1, 6, 1, 2'd3, 1, 1, 0, lv(1));
        step(0, 1, 6, 1, 2'd1, 1, 0, 0, lv(1));
        step(1, 0, 6, 1, 2'd2, 0, 0, 0, lv(1));
        step(0, 1, 6, 1, 2'd0, 0, 0, 1, lv(0));
        step(1, 0, 6, 1, 2'd1, 1, 0, 0, lv(0));
        step(1, 1, 6, 1, 2'd2, 0, 0, 0, lv(0));
        step(0, 1, 6, 1, 2'd0, 0, 0, 1, lv(0));
`ifdef STOPWATCH_LAP_CNT_EN
        step(1, 0, 6, 1, 2'd1, 1, 0, 0, 4'd0);
        for (int i = 1; i <= 17; i++) begin
            step(0, 1, 6, 1, 2'd3, 1, 1, 0, 4'(i > 15 ? 15 : i));
            step(0, 1, 6, 1, 2'd1, 1, 0, 0, 4'(i > 15 ? 15 : i));
        end
        step(1, 0, 6, 1, 2'd2, 0, 0, 0, 4'd15);
        step(0, 1, 6, 1, 2'd0, 0, 0, 1, 4'd0);
`endif
        repeat (20) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_changes got=%0d pending required=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Button-driven control FSM for the stopwatch datapath (freq_div plus the count10/count6 digit chain). It synchronizes and debounces two push-buttons and decodes them into start/stop/lap/clear commands. It drives the run enable, a one-cycle synchronous clear, and a lap display-freeze signal consumed by the display path. It sits between the board buttons and the frequency divider / digit counters.

Parameters:
DB_CYCLES, 4, consecutive clock cycles a synchronized button level must be stable before the debounced level changes (minimum 1).
DB_W, 8, width of each debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
btn_ss  input  1  raw start/stop button, active-high, asynchronous to clk
btn_lc  input  1  raw lap/clear button, active-high, asynchronous to clk
run  output  1  1 = divider and counters advance; 0 = frozen
clr  output  1  one-cycle synchronous clear pulse to the digit counters
lap_hold  output  1  1 = display latches and holds the current time; counting continues underneath
state  output  2  current FSM state (IDLE=0, RUN=1, STOP=2, LAP=3)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, run=0, clr=0, lap_hold=0. Synchronizers, debounce counters and debounced levels all cleared to 0. Reset asserted mid-operation aborts immediately to these values. Release is synchronous to the next clk edge.
- Input path, per button: 2-flop synchronizer -> debounce -> rising-edge detect.
  - Debounce counter resets to 0 whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments each cycle. When it reaches DB_CYCLES-1, the debounced level toggles and the counter returns to 0.
  - A press event is a 1-cycle pulse on the debounced 0->1 transition. Releases generate no event.
  - A raw pulse shorter than DB_CYCLES cycles after synchronization produces no event.
- Latency: if the raw level is first sampled high at edge N and held, the state register updates at edge N+DB_CYCLES+3. This latency is exact and the bench checks it.
- FSM transitions (ss = start/stop event, lc = lap/clear event):
  - IDLE: ss -> RUN. lc -> IDLE, with a clr pulse.
  - RUN: ss -> STOP. lc -> LAP.
  - LAP: ss -> STOP. lc -> RUN.
  - STOP: ss -> RUN. lc -> IDLE, with a clr pulse.
- Simultaneous ss and lc events in the same cycle: ss wins and lc is discarded, not queued.
- Outputs are registered (Moore) and change at the same edge as state:
  - run=1 in RUN and LAP, 0 in IDLE and STOP.
  - lap_hold=1 only in LAP.
  - clr=1 for exactly the cycle following each lc event taken in IDLE or STOP, then 0.
- Leaving LAP by either event drops lap_hold at the transition edge.
- A held button generates exactly one event; re-arming requires release for at least DB_CYCLES cycles.

Optional Feature:
STOPWATCH_LAP_CNT_EN
- Defined: adds output port lap_cnt (4 bits).
  - Increments on each RUN->LAP transition and saturates at 15 (no wrap).
  - Resets to 0 on rst and on every clr pulse, at the same edge clr asserts.
  - Unaffected by STOP.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset: rst=0 for 3 cycles with both buttons toggling -> run=0, clr=0, lap_hold=0, state=0 throughout; no event within DB_CYCLES+3 cycles of release while buttons are held low.
2. Start latency (DB_CYCLES=4): btn_ss raw high sampled at edge N, held 20 cycles -> state=1 and run=1 first at edge N+7, not N+6; the held button produces no second event.
3. Glitch rejection: btn_ss high for 2 cycles, then low -> state stays 0, run=0.
4. Full sequence:
   - ss, then lc -> state=3, lap_hold=1, run=1.
   - Then lc -> state=1, lap_hold=0.
   - Then ss -> state=2, run=0.
   - Then lc -> state=0 with clr high for exactly 1 cycle.
5. Simultaneous: in RUN, both buttons rise at the same edge -> state=2, lap_hold=0, clr=0; lc is dropped, so no LAP entry after release.
6. Lap counter (macro defined): 17 RUN<->LAP round trips -> lap_cnt=15. Then ss, lc (through STOP to IDLE) -> lap_cnt=0 at the clr edge.
